multiplier_datapath_taint: RTL and testbench

//  Shift-add datapath for the sequential multiplier, with bitwise taint tracking.
//  It is the receiving end of the controller's command interface: it executes

---
 rtl/multiplier_datapath_taint_if.sv | 43 ++++
 rtl/multiplier_datapath_taint.sv | 94 +++++++++
 tb/tb_multiplier_datapath_taint.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/multiplier_datapath_taint_if.sv
// rtl/multiplier_datapath_taint_if.sv - command/operand/product bundle between controller and datapath
interface multiplier_datapath_taint_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplicand_t;
    logic [WIDTH-1:0]   multiplier;
    logic [WIDTH-1:0]   multiplier_t;
    logic               mdld;
    logic               mdld_t;
    logic               mrld;
    logic               mrld_t;
    logic               rsclear;
    logic               rsclear_t;
    logic               rsload;
    logic               rsload_t;
    logic               rsshr;
    logic               rsshr_t;
    logic               productDone;
    logic               productDone_t;
    logic [WIDTH-1:0]   multiplierReg;
    logic               multiplierReg_t;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_t;
    logic               product_valid;
    logic               product_valid_t;

    modport master (
        output multiplicand, multiplicand_t, multiplier, multiplier_t,
        output mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t,
        output rsload, rsload_t, rsshr, rsshr_t, productDone, productDone_t,
        input  multiplierReg, multiplierReg_t, product, product_t,
        input  product_valid, product_valid_t
    );

    modport slave (
        input  multiplicand, multiplicand_t, multiplier, multiplier_t,
        input  mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t,
        input  rsload, rsload_t, rsshr, rsshr_t, productDone, productDone_t,
        output multiplierReg, multiplierReg_t, product, product_t,
        output product_valid, product_valid_t
    );
endinterface

// File: rtl/multiplier_datapath_taint.sv
// rtl/multiplier_datapath_taint.sv - shift-add multiplier datapath with per-bit taint shadow
module multiplier_datapath_taint #(
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    multiplier_datapath_taint_if.slave bus
);
    localparam int W = WIDTH;

    logic [W-1:0]   md, md_t, mr, mr_t;
    logic [2*W:0]   rs, rs_t, rs_nxt, rs_t_nxt;
    logic [2*W-1:0] p, p_t;
    logic           pv, pv_t;
    logic [W:0]     sum, sum_t, md_t_ext;
    logic           acc;

    // Add taint is a carry-chain prefix: bit i can be influenced by any lower operand bit.
    always_comb begin
        sum      = rs[2*W:W] + {1'b0, md};
        md_t_ext = {1'b0, md_t};
        acc      = 1'b0;
        sum_t    = '0;
        for (int i = 0; i <= W; i++) begin
            acc      = acc | rs_t[W+i] | md_t_ext[i];
            sum_t[i] = acc;
        end
    end

    always_comb begin
        rs_nxt   = rs;
        rs_t_nxt = rs_t;
        if (bus.rsclear) begin
            rs_nxt   = '0;
            rs_t_nxt = '0;
        end else if (bus.rsload) begin
            rs_nxt[2*W:W]   = sum;
            rs_t_nxt[2*W:W] = sum_t;
        end else if (bus.rsshr) begin
            rs_nxt   = {1'b0, rs[2*W:1]};
            rs_t_nxt = {1'b0, rs_t[2*W:1]};
        end
        // A tainted command may or may not have fired, so the whole register is suspect.
        if (bus.rsclear_t || bus.rsload_t || bus.rsshr_t) begin
            rs_t_nxt = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md   <= '0;
            md_t <= '0;
            mr   <= '0;
            mr_t <= '0;
            rs   <= '0;
            rs_t <= '0;
            p    <= '0;
            p_t  <= '0;
            pv   <= 1'b0;
            pv_t <= 1'b0;
        end else begin
            if (bus.mdld) begin
                md   <= bus.multiplicand;
                md_t <= bus.multiplicand_t;
            end
            if (bus.mdld_t) begin
                md_t <= '1;
            end
            if (bus.mrld) begin
                mr   <= bus.multiplier;
                mr_t <= bus.multiplier_t;
            end
            if (bus.mrld_t) begin
                mr_t <= '1;
            end
            rs   <= rs_nxt;
            rs_t <= rs_t_nxt;
            // RS[2W:1] before the final shift equals RS[2W-1:0] after it.
            if (bus.productDone) begin
                p   <= rs[2*W:1];
                p_t <= rs_t[2*W:1] | {(2*W){bus.productDone_t}};
            end
            pv   <= bus.productDone;
            pv_t <= bus.productDone_t;
        end
    end

    assign bus.multiplierReg   = mr;
    assign bus.multiplierReg_t = |mr_t;
    assign bus.product         = p;
    assign bus.product_t       = p_t;
    assign bus.product_valid   = pv;
    assign bus.product_valid_t = pv_t;
endmodule

// File: tb/tb_multiplier_datapath_taint.sv
// tb/tb_multiplier_datapath_taint.sv - directed self-checking bench for the taint-tracking multiplier datapath
module tb_multiplier_datapath_taint;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    multiplier_datapath_taint_if #(.WIDTH(4)) bus ();

    multiplier_datapath_taint #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_cmds();
        bus.mdld = 1'b0;        bus.mdld_t = 1'b0;
        bus.mrld = 1'b0;        bus.mrld_t = 1'b0;
        bus.rsclear = 1'b0;     bus.rsclear_t = 1'b0;
        bus.rsload = 1'b0;      bus.rsload_t = 1'b0;
        bus.rsshr = 1'b0;       bus.rsshr_t = 1'b0;
        bus.productDone = 1'b0; bus.productDone_t = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_cmds();
    endtask

    // Plays the controller: INIT, then shr / conditional load per bit, then FINAL shr.
    task automatic run_mult(input logic [3:0] a, input logic [3:0] b, input logic [3:0] at,
                            input logic [3:0] bt, input int lt_bit, input logic pd_t);
        bus.multiplicand = a;  bus.multiplicand_t = at;
        bus.multiplier   = b;  bus.multiplier_t   = bt;
        bus.mdld = 1'b1; bus.mrld = 1'b1; bus.rsclear = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.rsshr = 1'b1;
            tick();
            bus.rsload   = b[i];
            bus.rsload_t = (i == lt_bit);
            tick();
        end
        check("valid_before_final", {31'b0, bus.product_valid}, 32'd0);
        bus.rsshr = 1'b1; bus.productDone = 1'b1; bus.productDone_t = pd_t;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        bus.multiplicand = '0; bus.multiplicand_t = '0;
        bus.multiplier   = '0; bus.multiplier_t   = '0;
        clear_cmds();
        #12;
        check("rst_product",   {24'b0, bus.product},   32'd0);
        check("rst_product_t", {24'b0, bus.product_t}, 32'd0);
        check("rst_valid",     {31'b0, bus.product_valid}, 32'd0);
        check("rst_mr",        {28'b0, bus.multiplierReg}, 32'd0);
        check("rst_mr_t",      {31'b0, bus.multiplierReg_t}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 5 x 3
        run_mult(4'd5, 4'd3, 4'd0, 4'd0, -1, 1'b0);
        check("p5x3",        {24'b0, bus.product},   32'd15);
        check("p5x3_t",      {24'b0, bus.product_t}, 32'd0);
        check("p5x3_valid",  {31'b0, bus.product_valid},   32'd1);
        check("p5x3_vt",     {31'b0, bus.product_valid_t}, 32'd0);
        tick();
        check("p5x3_pulse",  {31'b0, bus.product_valid}, 32'd0);
        check("p5x3_hold",   {24'b0, bus.product},       32'd15);

        // Carry and zero operands
        run_mult(4'd15, 4'd15, 4'd0, 4'd0, -1, 1'b0);
        check("p15x15", {24'b0, bus.product}, 32'd225);
        run_mult(4'd0, 4'd9, 4'd0, 4'd0, -1, 1'b0);
        check("p0x9",   {24'b0, bus.product}, 32'd0);
        run_mult(4'd7, 4'd0, 4'd0, 4'd0, -1, 1'b0);
        check("p7x0",   {24'b0, bus.product}, 32'd0);

        // Tainted MD[0]: the add spreads taint to result bits 0..4, landing at product[4:0]
        run_mult(4'd5, 4'd1, 4'b0001, 4'd0, -1, 1'b0);
        check("pmdt",   {24'b0, bus.product},   32'd5);
        check("pmdt_t", {24'b0, bus.product_t}, 32'h1F);

        // Tainted rsload on the last load step: no shifts remain to clear the top
        run_mult(4'd5, 4'd8, 4'd0, 4'd0, 3, 1'b0);
        check("prst",   {24'b0, bus.product},   32'd40);
        check("prst_t", {24'b0, bus.product_t}, 32'hFF);

        // MR taint reaches multiplierReg_t, data unaffected
        run_mult(4'd3, 4'd5, 4'd0, 4'b0100, -1, 1'b0);
        check("pmrt",     {24'b0, bus.product},       32'd15);
        check("pmrt_t",   {24'b0, bus.product_t},     32'd0);
        check("mr_val",   {28'b0, bus.multiplierReg}, 32'd5);
        check("mr_t_on",  {31'b0, bus.multiplierReg_t}, 32'd1);
        bus.multiplier = 4'd9; bus.multiplier_t = 4'd0; bus.mrld = 1'b1;
        tick();
        check("mr_t_off", {31'b0, bus.multiplierReg_t}, 32'd0);
        bus.mrld_t = 1'b1;
        tick();
        check("mrld_t_val", {28'b0, bus.multiplierReg},   32'd9);
        check("mrld_t_tnt", {31'b0, bus.multiplierReg_t}, 32'd1);

        // Tainted productDone
        run_mult(4'd2, 4'd3, 4'd0, 4'd0, -1, 1'b1);
        check("ppdt",    {24'b0, bus.product},   32'd6);
        check("ppdt_t",  {24'b0, bus.product_t}, 32'hFF);
        check("ppdt_vt", {31'b0, bus.product_valid_t}, 32'd1);

        // Reset mid-sequence
        bus.multiplicand = 4'd9; bus.multiplier = 4'd9;
        bus.mdld = 1'b1; bus.mrld = 1'b1; bus.rsclear = 1'b1;
        tick();
        bus.rsshr = 1'b1;
        tick();
        rst_n = 1'b0;
        #2;
        check("mid_rst_p",     {24'b0, bus.product},       32'd0);
        check("mid_rst_pt",    {24'b0, bus.product_t},     32'd0);
        check("mid_rst_vt",    {31'b0, bus.product_valid_t}, 32'd0);
        check("mid_rst_mr",    {28'b0, bus.multiplierReg}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_mult(4'd6, 4'd7, 4'd0, 4'd0, -1, 1'b0);
        check("p6x7",       {24'b0, bus.product},   32'd42);
        check("p6x7_t",     {24'b0, bus.product_t}, 32'd0);
        check("p6x7_valid", {31'b0, bus.product_valid}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
